// File: rtl/uart_tx_sched.sv
// Two-requester round-robin byte scheduler that paces uart_we pulses one frame apart.
// Optional sticky overflow flags when built with `UART_TX_SCHED_OVF_EN.
module uart_tx_sched #(
  parameter int DEPTH        = 4,
  parameter int FRAME_CYCLES = 4400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_we,
  input  logic [7:0] req0_data,
  output logic       req0_full,
  input  logic       req1_we,
  input  logic [7:0] req1_data,
  output logic       req1_full,
  output logic       uart_we,
  output logic [7:0] wr_data,
  output logic       busy
`ifdef UART_TX_SCHED_OVF_EN
  ,
  input  logic       ovf_clr,
  output logic       req0_ovf,
  output logic       req1_ovf
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);
  localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    wr_data_reg, wr_data_next;
  logic          last_grant_reg, last_grant_next;
  logic          grant;

  logic [1:0] push_we;
  logic [7:0] push_data [2];
  logic [7:0] head [2];
  logic [1:0] nonempty;
  logic [1:0] full;
  logic [1:0] pop;

  assign push_we      = {req1_we, req0_we};
  assign push_data[0] = req0_data;
  assign push_data[1] = req1_data;

`ifdef UART_TX_SCHED_OVF_EN
  logic [1:0] ovf;
  assign req0_ovf = ovf[0];
  assign req1_ovf = ovf[1];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]    mem [DEPTH];
      logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [PW:0]   count_reg;
      logic          push;

      // Fullness ignores a same-cycle pop, so a push to a full FIFO is always dropped.
      assign full[gi]     = (count_reg == DEPTH_C);
      assign nonempty[gi] = (count_reg != '0);
      assign push         = push_we[gi] & ~full[gi];
      assign head[gi]     = mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= push_data[gi];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push)    wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + PW'(1);
          case ({push, pop[gi]})
            2'b10:   count_reg <= count_reg + (PW + 1)'(1);
            2'b01:   count_reg <= count_reg - (PW + 1)'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

`ifdef UART_TX_SCHED_OVF_EN
      logic ovf_reg;
      // A drop in the same cycle as a clear keeps the flag set.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         ovf_reg <= 1'b0;
        else if (push_we[gi] && full[gi])   ovf_reg <= 1'b1;
        else if (ovf_clr)                   ovf_reg <= 1'b0;
      end
      assign ovf[gi] = ovf_reg;
`endif
    end
  endgenerate

  // Lone requester wins outright; on a tie the one not granted last time wins.
  assign grant = (nonempty == 2'b11) ? ~last_grant_reg : nonempty[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      wr_data_reg    <= 8'h00;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      wr_data_reg    <= wr_data_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    wr_data_next    = wr_data_reg;
    last_grant_next = last_grant_reg;
    pop             = 2'b00;
    uart_we         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (nonempty != 2'b00) begin
          pop[grant]      = 1'b1;
          wr_data_next    = head[grant];
          last_grant_next = grant;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        uart_we    = 1'b1;
        cnt_next   = CNT_LOAD;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_data   = wr_data_reg;
  assign req0_full = full[0];
  assign req1_full = full[1];
  assign busy      = (state_reg != IDLE) | (|nonempty);

endmodule
